id_stage: RTL
=============

# id_stage

Instruction-decode stage of the GPU pipeline, the consumer end of the fetch interface. Accepts the fetched instruction word and its PC, decodes it into registered fields for execute, and drives the fetch control signals back: `Stall` for load-use hazards, and `Loop`/`PC_in` for the single-level hardware loop. Also squashes the one wrong-path instruction that fetch delivers after every loop redirect.

## Interface
Parameters:
- none. ISA constants come from the shared package.

Ports:
- `CLOCK_50` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `id_instr` in 32: instruction word from fetch. Fields:
  - op [31:28]
  - rd [27:24]
  - rs [23:20]
  - rt [19:16]
  - imm [15:0]
- `fe_pc` in 16: fetch `PC_out`. Leads `id_instr` by one cycle.
- `Stall` out 1: freezes fetch. Combinational from registered state only.
- `Loop` out 1: redirect fetch to `PC_in`. Combinational from registered state only.
- `PC_in` out 16: redirect target (`loop_start`). Defined only when `Loop`=1, else 0.
- `ex_valid` out 1: execute-stage instruction is real.
- `ex_op` out 4, `ex_rd` out 4, `ex_rs` out 4, `ex_rt` out 4, `ex_imm` out 16, `ex_pc` out 16: registered decode outputs.

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD (reads rs, rt)
  - 2 SUB (reads rs, rt)
  - 3 LDI (no reads)
  - 4 LD (reads rs; 2-cycle result)
  - 5 ST (reads rs, rt)
  - 6 LOOPSET
  - 7 LOOPEND
  - 8–15 treated as NOP
- `pc_d`: `fe_pc` registered on each non-stalled edge. It is the PC of the current `id_instr`.
- Per-cycle priority: squash > stall > loop > normal issue.
- **Squash:** `squash` is set on any edge where `Loop`=1, and cleared on the next edge. While it is 1:
  - current instruction dropped (`ex_valid`<=0)
  - `Stall`=0, `Loop`=0
  - no loop state change
- **Stall (load-use):**
  - Condition: `ex_valid`=1, `ex_op`=LD, and the current instruction reads `ex_rd` through rs or rt, per the table above.
  - Then `Stall`=1 and a bubble issues (`ex_valid`<=0). Fetch holds, so the same instruction re-presents next cycle and issues then.
  - Register 0 is not special.
- **LOOPSET:**
  - `loop_cnt` <= imm; imm 0 loads 1.
  - `loop_start` <= `pc_d`+1.
  - `loop_act` <= 1.
  - `ex_valid`<=0.
  - A LOOPSET while a loop is active overwrites it (single level).
- **LOOPEND:** `ex_valid`<=0.
  - If `loop_act` and `loop_cnt`>1: `Loop`=1, `PC_in`=`loop_start`, `loop_cnt` decrements.
  - Otherwise: `loop_act`<=0, `loop_cnt`<=0, and execution falls through.
  - A LOOPEND with no active loop is a NOP.
- LOOPSET and LOOPEND never stall.
- **Normal issue:** `ex_valid`<=1 for opcodes 1–5, 0 otherwise. Fields are copied; `ex_pc`<=`pc_d`.
- Arithmetic: `pc_d`+1 and `loop_cnt` decrement are 16-bit and wrap silently.

## Timing
- Decode latency: 1 cycle (`id_instr` to `ex_*`).
- Redirect cost:
  - `Loop` at edge t.
  - Wrong-path word (loop-end PC+1) present in cycle t+1; squashed.
  - Target instruction at decode in cycle t+2, with `pc_d`=`PC_in`.
- Load-use cost: exactly one bubble per hazard.
- Reset values (asynchronous):
  - all `ex_*` = 0
  - `squash` = 0, `loop_act` = 0, `loop_cnt` = 0, `loop_start` = 0, `pc_d` = 0
  - so `Stall` = 0, `Loop` = 0, `PC_in` = 0
- Reset mid-loop abandons the loop; no redirect after release.
- Post-reset: fetch supplies zero words for two cycles. These decode as NOP.

## Structure
- Shared package `gpu_isa_pkg`:
  - opcode localparams (`OP_NOP` … `OP_LOOPEND`)
  - field bit positions
  - register-index width (4)
  - PC width (16)
- Sub-module `loop_ctrl`:
  - owns `loop_act`, `loop_cnt`, `loop_start`
  - inputs: `is_loopset`, `is_loopend`, `imm`, `pc_d`, `squash`
  - outputs: `Loop`, `PC_in`
- Hazard compare and field registers stay in `id_stage`.

## Test plan
- **Reset:** assert `reset` mid-stream with `loop_act`=1.
  - During reset: all outputs 0.
  - After release, feed LOOPEND: no `Loop`; `ex_valid`=0.
- **ALU issue:** ADD r3,r1,r2 at PC 5.
  - Next cycle: `ex_valid`=1, `ex_op`=1, `ex_rd`=3, `ex_rs`=1, `ex_rt`=2, `ex_pc`=5.
  - `Stall` never asserts.
- **Load-use:** LD r4 followed by ADD r5,r4,r1.
  - `Stall`=1 for exactly one cycle, then a bubble (`ex_valid`=0), then ADD issues.
  - Repeat with ADD r5,r1,r2: no stall.
- **Loop, count 3:** LOOPSET imm=3 at PC 10, body at PCs 11–12, LOOPEND at PC 13.
  - `Loop`=1 with `PC_in`=11 twice.
  - Wrong-path PC 14 is squashed each time.
  - Body issues 3 times.
  - PC 14 then issues once.
- **Loop, count 0:** LOOPSET imm=0.
  - Body executes once; LOOPEND falls through.
- **Overwrite:** a second LOOPSET inside an active loop replaces count and start; the earlier loop is never resumed.

Source files
------------

// File: rtl/gpu_isa_pkg.sv
// Shared GPU ISA constants: opcodes, instruction field positions and widths.
// Decode helpers classify which register operands each opcode reads.
package gpu_isa_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned REG_W = 4;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned PC_W  = 16;

  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS_LSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP     = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD     = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB     = 4'd2;
  localparam logic [OP_W-1:0] OP_LDI     = 4'd3;
  localparam logic [OP_W-1:0] OP_LD      = 4'd4;
  localparam logic [OP_W-1:0] OP_ST      = 4'd5;
  localparam logic [OP_W-1:0] OP_LOOPSET = 4'd6;
  localparam logic [OP_W-1:0] OP_LOOPEND = 4'd7;

  // Opcodes that reach execute as real instructions; 8-15 are NOPs.
  function automatic logic op_issues(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_LDI, OP_LD, OP_ST: return 1'b1;
      OP_NOP, OP_LOOPSET, OP_LOOPEND:       return 1'b0;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_rs(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_LD, OP_ST: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_rt(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ST: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/loop_ctrl.sv
// Single-level hardware loop: holds start PC and remaining count, and
// requests a fetch redirect when a LOOPEND still has iterations left.
module loop_ctrl
  import gpu_isa_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             is_loopset,
  input  logic             is_loopend,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  pc_d,
  input  logic             squash,
  output logic             Loop,
  output logic [PC_W-1:0]  PC_in
);

  logic            loop_act_q;
  logic [PC_W-1:0] loop_cnt_q;
  logic [PC_W-1:0] loop_start_q;
  logic            take_loop;

  assign take_loop = !squash && is_loopend && loop_act_q && (loop_cnt_q > 16'd1);
  assign Loop      = take_loop;
  assign PC_in     = take_loop ? loop_start_q : '0;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      loop_act_q   <= 1'b0;
      loop_cnt_q   <= '0;
      loop_start_q <= '0;
    end else if (!squash) begin
      if (is_loopset) begin
        // A zero count still runs the body once.
        loop_cnt_q   <= (imm == '0) ? 16'd1 : imm;
        loop_start_q <= pc_d + 16'd1;
        loop_act_q   <= 1'b1;
      end else if (is_loopend) begin
        if (take_loop) begin
          loop_cnt_q <= loop_cnt_q - 16'd1;
        end else begin
          loop_act_q <= 1'b0;
          loop_cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode: registers fields for execute, detects load-use hazards,
// and drives fetch Stall/Loop/PC_in with one-cycle squash after each redirect.
module id_stage
  import gpu_isa_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [31:0]       id_instr,
  input  logic [PC_W-1:0]   fe_pc,
  output logic              Stall,
  output logic              Loop,
  output logic [PC_W-1:0]   PC_in,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [REG_W-1:0]  ex_rd,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [IMM_W-1:0]  ex_imm,
  output logic [PC_W-1:0]   ex_pc
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  pc_d;
  logic             squash_q;
  logic             hazard;

  assign op  = id_instr[OP_LSB +: OP_W];
  assign rd  = id_instr[RD_LSB +: REG_W];
  assign rs  = id_instr[RS_LSB +: REG_W];
  assign rt  = id_instr[RT_LSB +: REG_W];
  assign imm = id_instr[IMM_LSB +: IMM_W];

  // Register 0 is an ordinary register here, so no zero-index exemption.
  assign hazard = ex_valid && (ex_op == OP_LD) &&
                  ((op_reads_rs(op) && (rs == ex_rd)) || (op_reads_rt(op) && (rt == ex_rd)));
  assign Stall  = !squash_q && hazard;

  loop_ctrl u_loop_ctrl (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .is_loopset ((op == OP_LOOPSET) && !Stall),
    .is_loopend ((op == OP_LOOPEND) && !Stall),
    .imm        (imm),
    .pc_d       (pc_d),
    .squash     (squash_q),
    .Loop       (Loop),
    .PC_in      (PC_in)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      squash_q <= 1'b0;
      pc_d     <= '0;
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_imm   <= '0;
      ex_pc    <= '0;
    end else begin
      squash_q <= Loop;
      if (!Stall) begin
        pc_d <= fe_pc;
      end
      if (squash_q || Stall) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= op_issues(op);
        ex_op    <= op;
        ex_rd    <= rd;
        ex_rs    <= rs;
        ex_rt    <= rt;
        ex_imm   <= imm;
        ex_pc    <= pc_d;
      end
    end
  end

endmodule
